// File: rtl/mlaccel_pkg.sv
// Shared instruction-word definitions for the mlaccel sequencer and decoder.
package mlaccel_pkg;

  localparam int OPC_LSB  = 0;
  localparam int OPC_W    = 6;
  localparam int ADDR_LSB = 6;
  localparam int ADDR_W   = 11;
  localparam int CNT_LSB  = 17;
  localparam int CNT_W    = 15;

  typedef enum logic [OPC_W-1:0] {
    OPC_SYNC   = 6'd0,
    OPC_CALL   = 6'd1,
    OPC_RETURN = 6'd2,
    OPC_EXEC   = 6'd3
  } opcode_e;

  function automatic logic [OPC_W-1:0] insn_opcode(input logic [31:0] w);
    return w[OPC_LSB +: OPC_W];
  endfunction

  function automatic logic [ADDR_W-1:0] insn_addr(input logic [31:0] w);
    return w[ADDR_LSB +: ADDR_W];
  endfunction

  function automatic logic [CNT_W-1:0] insn_count(input logic [31:0] w);
    return w[CNT_LSB +: CNT_W];
  endfunction

endpackage

// File: rtl/mlaccel_credit_counter.sv
// Outstanding-operation counter: saturates at zero and flags a decrement at zero.
module mlaccel_credit_counter #(
  parameter int MAX = 16,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          underflow_o
);

  logic [CW-1:0] count_q, count_d;

  // Simultaneous increment and decrement cancel out.
  always_comb begin
    count_d = count_q;
    if (inc_i && !dec_i) begin
      count_d = count_q + CW'(1);
    end else if (dec_i && !inc_i && (count_q != '0)) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o     = count_q;
  assign full_o      = (count_q == CW'(MAX));
  assign underflow_o = dec_i && (count_q == '0);

endmodule

// File: rtl/mlaccel_insn_decoder.sv
// Decodes sequencer instruction words into execute operations and sync barriers,
// throttling issue against the number of operations still in flight.
module mlaccel_insn_decoder
  import mlaccel_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 16
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        comp_valid,
  output logic        comp_ready,
  input  logic [31:0] comp_data,
  output logic        exec_valid,
  input  logic        exec_ready,
  output logic [10:0] exec_addr,
  output logic        exec_last,
  input  logic        exec_done,
  output logic        sync_pulse,
  output logic        busy,
  output logic        err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, SYNC_WAIT} state_e;

  state_e              state_q, state_d;
  logic                live_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                last_q, last_d;
  logic                err_q, err_d;
  logic [CW-1:0]       outstanding;
  logic                cnt_full, cnt_underflow;
  logic [OPC_W-1:0]    opcode;

  assign opcode = insn_opcode(comp_data);

  // live_q holds comp_ready low until the first edge after reset is released.
  assign comp_ready = live_q && (state_q == IDLE);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    last_d     = last_q;
    err_d      = err_q || cnt_underflow;
    exec_valid = 1'b0;
    sync_pulse = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (comp_valid && live_q) begin
          if (opcode == OPC_EXEC) begin
            state_d = ISSUE;
            addr_d  = insn_addr(comp_data);
            last_d  = (insn_count(comp_data) == CNT_W'(1));
          end else if (opcode == OPC_SYNC) begin
            state_d = SYNC_WAIT;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        exec_valid = !cnt_full;
        if (!cnt_full && exec_ready) begin
          state_d = IDLE;
        end
      end
      SYNC_WAIT: begin
        if (outstanding == '0) begin
          sync_pulse = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      live_q  <= 1'b0;
      addr_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  mlaccel_credit_counter #(
    .MAX (MAX_OUTSTANDING),
    .CW  (CW)
  ) u_credit (
    .clk_i       (clock),
    .rst_i       (reset),
    .inc_i       (exec_valid && exec_ready),
    .dec_i       (exec_done),
    .count_o     (outstanding),
    .full_o      (cnt_full),
    .underflow_o (cnt_underflow)
  );

  assign exec_addr = addr_q;
  assign exec_last = last_q;
  assign err       = err_q;
  assign busy      = (state_q != IDLE) || (outstanding != '0);

endmodule

// File: tb/tb_mlaccel_insn_decoder.sv
// Self-checking bench for mlaccel_insn_decoder: directed table, corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mlaccel_insn_decoder;

  localparam int MAXO = 16;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        comp_valid = 1'b0;
  logic [31:0] comp_data = '0;
  logic        exec_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        comp_ready, exec_valid, exec_last, sync_pulse, busy, err;
  logic [10:0] exec_addr;

  always #5 clock = ~clock;

  mlaccel_insn_decoder #(.MAX_OUTSTANDING(MAXO)) dut (
    .clock      (clock),
    .reset      (reset),
    .comp_valid (comp_valid),
    .comp_ready (comp_ready),
    .comp_data  (comp_data),
    .exec_valid (exec_valid),
    .exec_ready (exec_ready),
    .exec_addr  (exec_addr),
    .exec_last  (exec_last),
    .exec_done  (exec_done),
    .sync_pulse (sync_pulse),
    .busy       (busy),
    .err        (err)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: at most one held instruction (0 none, 1 execute, 2 sync)
  int          m_out;
  bit          m_err, m_live;
  int          m_held;
  logic [10:0] m_addr;
  bit          m_last;

  typedef struct {
    bit          cv;
    logic [31:0] d;
    bit          er, dn;
    bit          rdy, vld;
    logic [10:0] addr;
    bit          last, syn, bsy, er_flag;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t row(bit cv, logic [31:0] d, bit er, bit dn, bit rdy, bit vld,
                               logic [10:0] a, bit last, bit syn, bit bsy, bit ef);
    vec_t v;
    v.cv = cv; v.d = d; v.er = er; v.dn = dn; v.rdy = rdy; v.vld = vld;
    v.addr = a; v.last = last; v.syn = syn; v.bsy = bsy; v.er_flag = ef;
    return v;
  endfunction

  function automatic logic [31:0] mk(int opc, int addr, int cnt);
    return (32'(cnt & 'h7fff) << 17) | (32'(addr & 'h7ff) << 6) | 32'(opc & 63);
  endfunction

  function automatic logic [31:0] rnd_insn();
    int sel, opc, cnt;
    sel = $urandom_range(0, 9);
    cnt = $urandom_range(0, 32767);
    if (sel < 4) opc = 3;
    else if (sel < 7) opc = 0;
    else if (sel == 7) opc = $urandom_range(1, 2);
    else if (sel == 8) opc = $urandom_range(4, 63);
    else begin opc = 3; cnt = 1; end
    return mk(opc, $urandom_range(0, 2047), cnt);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(bit cv, logic [31:0] d, bit er, bit dn);
    comp_valid = cv; comp_data = d; exec_ready = er; exec_done = dn;
  endtask

  task automatic model_check();
    chk("ready", comp_ready, (m_live && m_held == 0));
    chk("exec_valid", exec_valid, (m_held == 1 && m_out < MAXO));
    chk("exec_addr", exec_addr, m_addr);
    chk("exec_last", exec_last, m_last);
    chk("sync_pulse", sync_pulse, (m_held == 2 && m_out == 0));
    chk("busy", busy, (m_held != 0 || m_out != 0));
    chk("err", err, m_err);
  endtask

  // Check outputs, advance the model with the current inputs, move to next cycle.
  task automatic step();
    bit rdy, vld, syn, hs;
    int opc;
    model_check();
    rdy = m_live && m_held == 0;
    vld = m_held == 1 && m_out < MAXO;
    syn = m_held == 2 && m_out == 0;
    hs  = vld && exec_ready;
    if (rdy && comp_valid) begin
      opc = int'(comp_data[5:0]);
      if (opc == 3) begin
        m_held = 1;
        m_addr = comp_data[16:6];
        m_last = (comp_data[31:17] == 15'd1);
      end else if (opc == 0) begin
        m_held = 2;
      end else begin
        m_err = 1'b1;
      end
    end
    if (hs || syn) m_held = 0;
    if (exec_done && m_out == 0) m_err = 1'b1;
    if (hs && !exec_done) m_out++;
    else if (exec_done && !hs && m_out > 0) m_out--;
    m_live = 1'b1;
    @(negedge clock);
  endtask

  // Reset asserted mid-cycle; outputs must clear before any clock edge.
  task automatic do_reset();
    #2;
    reset = 1'b1;
    apply(0, '0, 0, 0);
    #1;
    chk("rst_ready", comp_ready, 0);
    chk("rst_valid", exec_valid, 0);
    chk("rst_addr", exec_addr, 0);
    chk("rst_last", exec_last, 0);
    chk("rst_sync", sync_pulse, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    m_out = 0; m_err = 0; m_live = 0; m_held = 0; m_addr = '0; m_last = 0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  initial begin
    int pulses, pulse_k;

    tbl[0]  = row(1, 32'h00060043, 1, 0,  1, 0, 11'h000, 0, 0, 0, 0);
    tbl[1]  = row(0, 32'h0,        1, 0,  0, 1, 11'h001, 0, 0, 1, 0);
    tbl[2]  = row(0, 32'h0,        0, 0,  1, 0, 11'h001, 0, 0, 1, 0);
    tbl[3]  = row(0, 32'h0,        0, 1,  1, 0, 11'h001, 0, 0, 1, 0);
    tbl[4]  = row(1, 32'h00000002, 0, 0,  1, 0, 11'h001, 0, 0, 0, 0);
    tbl[5]  = row(0, 32'h0,        0, 0,  1, 0, 11'h001, 0, 0, 0, 1);
    tbl[6]  = row(1, 32'h0003FFC3, 0, 0,  1, 0, 11'h001, 0, 0, 0, 1);
    tbl[7]  = row(0, 32'h0,        0, 0,  0, 1, 11'h7FF, 1, 0, 1, 1);
    tbl[8]  = row(0, 32'h0,        1, 0,  0, 1, 11'h7FF, 1, 0, 1, 1);
    tbl[9]  = row(1, 32'h00000000, 0, 0,  1, 0, 11'h7FF, 1, 0, 1, 1);
    tbl[10] = row(0, 32'h0,        0, 0,  0, 0, 11'h7FF, 1, 0, 1, 1);
    tbl[11] = row(0, 32'h0,        0, 1,  0, 0, 11'h7FF, 1, 0, 1, 1);
    tbl[12] = row(0, 32'h0,        0, 0,  0, 0, 11'h7FF, 1, 1, 1, 1);
    tbl[13] = row(1, 32'h00000000, 0, 0,  1, 0, 11'h7FF, 1, 0, 0, 1);
    tbl[14] = row(0, 32'h0,        0, 0,  0, 0, 11'h7FF, 1, 1, 1, 1);
    tbl[15] = row(0, 32'h0,        0, 0,  1, 0, 11'h7FF, 1, 0, 0, 1);

    @(negedge clock);
    do_reset();
    apply(0, '0, 0, 0);
    step();

    // Directed table
    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].cv, tbl[i].d, tbl[i].er, tbl[i].dn);
      chk($sformatf("tbl%0d_ready", i), comp_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_valid", i), exec_valid, tbl[i].vld);
      chk($sformatf("tbl%0d_addr", i), exec_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_last", i), exec_last, tbl[i].last);
      chk($sformatf("tbl%0d_sync", i), sync_pulse, tbl[i].syn);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er_flag);
      if (i == 2) chk("outstanding_after_issue", dut.outstanding, 1);
      step();
    end

    // Sync waits for the single outstanding execute to complete
    do_reset();
    apply(0, '0, 0, 0); step();
    apply(1, mk(3, 5, 1), 1, 0); step();
    apply(0, '0, 1, 0); step();
    apply(1, mk(0, 0, 0), 0, 0); step();
    pulses = 0; pulse_k = -1;
    for (int k = 0; k < 10; k++) begin
      apply(0, '0, 0, (k == 4));
      if (sync_pulse === 1'b1) begin pulses++; pulse_k = k; end
      step();
    end
    chk("sync_pulse_count", pulses, 1);
    chk("sync_pulse_cycle", pulse_k, 5);
    chk("busy_after_sync", busy, 0);

    // Fill to MAX outstanding, then the throttled 17th issue
    do_reset();
    apply(0, '0, 0, 0); step();
    for (int i = 0; i < MAXO; i++) begin
      apply(1, mk(3, i, 2), 0, 0); step();
      apply(0, '0, 1, 0); step();
    end
    apply(1, mk(3, 99, 2), 1, 0); step();
    apply(0, '0, 1, 0);
    chk("full_valid_low", exec_valid, 0);
    chk("full_busy", busy, 1);
    step();
    apply(0, '0, 1, 1);
    chk("full_done_same_cycle", exec_valid, 0);
    step();
    apply(0, '0, 1, 0);
    chk("full_reenabled", exec_valid, 1);
    step();
    for (int i = 0; i < MAXO - 4; i++) begin
      apply(0, '0, 0, 1); step();
    end
    chk("outstanding_4", dut.outstanding, 4);
    apply(1, mk(3, 7, 1), 0, 0); step();
    apply(0, '0, 1, 1); step();
    chk("hs_and_done_hold", dut.outstanding, 4);
    for (int i = 0; i < 4; i++) begin
      apply(0, '0, 0, 1); step();
    end
    chk("drained_err_clear", err, 0);
    apply(0, '0, 0, 1); step();
    chk("underflow_err", err, 1);
    chk("underflow_count", dut.outstanding, 0);

    // Reset while an execute is held unaccepted
    do_reset();
    apply(0, '0, 0, 0); step();
    apply(1, mk(3, 3, 4), 0, 0); step();
    apply(0, '0, 0, 0);
    chk("issue_before_reset", exec_valid, 1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      apply(0, '0, 1, 0); step();
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 3000; i++) begin
      if (i % 500 == 499) begin
        do_reset();
      end
      apply(($urandom_range(0, 1) == 1), rnd_insn(),
            ($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
